// File: rtl/capture_ctl_if.sv
// rtl/capture_ctl_if.sv - capture sequencer frame inputs and DPRAM write-port bundle
interface capture_ctl_if #(
  parameter int CHANNELS = 8,
  parameter int DW       = 16,
  parameter int AW       = 8
);
  logic [5:0]             frame_posn;
  logic [CHANNELS*DW-1:0] d_in;
  logic                   enable;
  logic                   oneshot;
  logic                   we;
  logic [AW-1:0]          waddr;
  logic [DW-1:0]          wdata;
  logic [AW-1:0]          wr_ptr;
  logic                   busy;
  logic                   done;
  logic                   overrun;

  modport master (
    output frame_posn, d_in, enable, oneshot,
    input  we, waddr, wdata, wr_ptr, busy, done, overrun
  );

  modport slave (
    input  frame_posn, d_in, enable, oneshot,
    output we, waddr, wdata, wr_ptr, busy, done, overrun
  );
endinterface

// File: rtl/capture_ctl.sv
// rtl/capture_ctl.sv - frame-synchronous capture of a channel bank into DPRAM bursts
// Ring or one-shot fill; one burst of CHANNELS words per I2S frame start.
module capture_ctl #(
  parameter int CHANNELS = 8,
  parameter int DW       = 16,
  parameter int AW       = 8
) (
  input  logic           ck,
  input  logic           rst,
  capture_ctl_if.slave   cap
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;
  localparam int CW = $clog2(CHANNELS + 1);

  logic [1:0]             r_state;
  logic [5:0]             r_prev_posn;
  logic [CHANNELS*DW-1:0] r_shadow;
  logic [CW-1:0]          r_ch;
  logic                   r_mode;
  logic                   r_we;
  logic [AW-1:0]          r_waddr;
  logic [DW-1:0]          r_wdata;
  logic [AW-1:0]          r_wr_ptr;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_overrun;

  logic                   w_fs;
  logic [DW-1:0]          w_word;

  assign w_fs = (cap.frame_posn == 6'd0) && (r_prev_posn != 6'd0);

  always_comb begin
    w_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (r_ch == CW'(k)) w_word = r_shadow[k*DW +: DW];
    end
  end

  // Channel 0 is issued straight from d_in on the fs edge, so r_ch counts the next channel to issue.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_prev_posn <= '0;
      r_shadow    <= '0;
      r_ch        <= '0;
      r_mode      <= 1'b0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_wr_ptr    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_prev_posn <= cap.frame_posn;
      case (r_state)
        S_IDLE: begin
          if (cap.enable) begin
            r_state   <= S_WAIT;
            r_mode    <= cap.oneshot;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_wr_ptr  <= '0;
          end
        end
        S_WAIT: begin
          if (!cap.enable) begin
            r_state <= S_IDLE;
          end else if (w_fs) begin
            r_shadow <= cap.d_in;
            r_we     <= 1'b1;
            r_busy   <= 1'b1;
            r_waddr  <= r_wr_ptr;
            r_wdata  <= cap.d_in[DW-1:0];
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_ch     <= CW'(1);
            r_state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_fs) r_overrun <= 1'b1;
          if (r_ch != CW'(CHANNELS)) begin
            r_waddr  <= r_wr_ptr;
            r_wdata  <= w_word;
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_ch     <= r_ch + 1'b1;
          end else begin
            r_we   <= 1'b0;
            r_busy <= 1'b0;
            if (r_mode && (r_wr_ptr == '0)) begin
              r_done  <= 1'b1;
              r_state <= S_HOLD;
            end else if (cap.enable) begin
              r_state <= S_WAIT;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (!cap.enable) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cap.we      = r_we;
  assign cap.waddr   = r_waddr;
  assign cap.wdata   = r_wdata;
  assign cap.wr_ptr  = r_wr_ptr;
  assign cap.busy    = r_busy;
  assign cap.done    = r_done;
  assign cap.overrun = r_overrun;
endmodule

// File: doc/capture_ctl.md
# capture_ctl

Frame-synchronous capture sequencer that owns the DPRAM write port. On each I2S frame start it snapshots a packed bank of channel words (left, right, diagnostics) and writes them as a burst of consecutive words into the DPRAM. It supports continuous ring-buffer capture and one-shot fill capture. It sits between the I2S_CLOCK/I2S_RX outputs and the DPRAM write port.

## Interface

Parameters:
- CHANNELS, 8, words captured per frame; 2^AW must be an integer multiple of CHANNELS.
- DW, 16, word width.
- AW, 8, DPRAM address width.

Ports:
- ck  in  1  system clock; the I2S clock divider runs on the same clock, so frame_posn is synchronous to ck.
- rst  in  1  reset, asynchronous, active-high.
- frame_posn  in  6  bit position within the 64-bit I2S frame.
- d_in  in  CHANNELS*DW  packed channel words; channel k occupies bits [k*DW +: DW].
- enable  in  1  arm level; high = capture running.
- oneshot  in  1  mode select, sampled on leaving IDLE; 1 = fill buffer once, 0 = ring.
- we  out  1  DPRAM write enable.
- waddr  out  AW  DPRAM write address.
- wdata  out  DW  DPRAM write data.
- wr_ptr  out  AW  address of the next word to be written.
- busy  out  1  high while in state WRITE.
- done  out  1  one-shot buffer full (sticky).
- overrun  out  1  a frame start was missed during WRITE (sticky).

## Operation

- Frame start (fs): frame_posn == 0 in this cycle, and the registered previous frame_posn != 0. The registered previous value resets to 0, so no fs is detected in the first cycle after reset.
- States:
  - IDLE: we=0.
    - enable=1 → go to WAIT; latch oneshot into the mode register; clear done, overrun and wr_ptr.
  - WAIT: enable=0 → IDLE. Otherwise fs → snapshot all of d_in into a shadow register, set channel counter to 0, go to WRITE.
  - WRITE: one word per cycle. wdata = shadow channel k, waddr = wr_ptr, we=1, wr_ptr += 1 (mod 2^AW).
    - After channel CHANNELS-1:
      - one-shot mode, and wr_ptr has wrapped to 0 → set done, go to HOLD.
      - else if enable=1 → WAIT.
      - else → IDLE.
  - HOLD: we=0, done=1. enable=0 → IDLE.
- A frame is never split. If enable drops during WRITE, the burst completes before the block returns to IDLE.
- fs during WRITE: set overrun; that frame is skipped; the burst in progress is not disturbed.
- Ring mode: wr_ptr wraps silently; the oldest data is overwritten. done is never set.
- Arming mid-frame: capture starts at the next fs only, so the buffer is always frame-aligned.
- Each buffer entry holds CHANNELS words from a single snapshot. d_in changing during WRITE does not affect the burst.

## Timing

- Reset values: we=0, waddr=0, wdata=0, wr_ptr=0, busy=0, done=0, overrun=0; state IDLE; shadow register = 0.
- Reset asserted mid-burst: all outputs go to their reset values immediately (asynchronously); no further writes occur.
- All outputs are registered.
- fs detected in cycle t (state WAIT):
  - we=1 in cycles t+1 .. t+CHANNELS.
  - Channel 0 is written in cycle t+1.
  - busy is high in the same cycles as we.
- First word of frame n (counting from arming, n=0) lands at address (n*CHANNELS) mod 2^AW.
- State returns to WAIT or IDLE in cycle t+CHANNELS+1. An fs in that cycle is accepted. Minimum fs spacing without overrun is CHANNELS+1 cycles.
- One-shot with defaults: 32 frames fill 256 words. done rises in the cycle after the last write, i.e. together with the state change to HOLD.

## Test plan

- Reset, then enable=1, oneshot=0, with d_in channel k = 16'h1000+k. Drive frame_posn 63→0. Required: we high for exactly 8 cycles starting one cycle after fs; waddr 0..7; wdata 1000..1007; wr_ptr=8 afterwards.
- Ring wrap: 33 frames in ring mode. Required: frame 32 writes addresses 0..7; wr_ptr=8; done stays 0.
- One-shot: oneshot=1, 32 frames. Required: done=1 after the write to address 255; no we on frames 33+; enable=0 returns to IDLE; re-arm clears done and wr_ptr.
- Overrun: force frame_posn back to 0 (from a nonzero value) 3 cycles into a burst. Required: overrun=1; the burst still writes all 8 words unchanged; that frame is not captured; the next normal fs captures at waddr 8.
- enable dropped at channel 2 of a burst. Required: all 8 writes complete, then IDLE with we=0; a later fs produces no writes.
- rst pulsed during channel 4 of a burst. Required: we=0 immediately; all outputs return to 0; the next arm restarts at waddr 0.
